// File: rtl/mux_sweep_pkg.sv
// Shared definitions for the 6-to-1 mux sweep sequencer: state encoding and
// select/capture widths.
package mux_sweep_pkg;

  localparam int SEL_WIDTH        = 3;
  localparam int CAP_WIDTH        = 6;
  localparam int DEFAULT_LAST_SEL = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/rate_divider.sv
// Dwell counter: counts 0..period while enabled and flags the cycle where the
// count reaches period, wrapping back to zero on that cycle.
module rate_divider #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  // Tick is qualified by enable so a frozen divider never reports a sample.
  assign tick = enable && (count == period);

  always_ff @(posedge CLOCK_50) begin
    if (RESET || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == period) begin
        count <= '0;
      end else begin
        count <= count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mux_sweep_ctrl.sv
// Sweeps the mux select through 0..LAST_SEL at a programmable dwell and
// assembles the sampled mux output into a capture word.
module mux_sweep_ctrl
  import mux_sweep_pkg::*;
#(
  parameter int DIV_WIDTH = 26,
  parameter int LAST_SEL  = DEFAULT_LAST_SEL
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 HOLD,
  input  logic [DIV_WIDTH-1:0] RATE,
  input  logic                 MUX_OUT,
  output logic [SEL_WIDTH-1:0] SELECT,
  output logic [CAP_WIDTH-1:0] CAPTURE,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(LAST_SEL);

  state_t               state;
  state_t               state_nxt;
  logic [DIV_WIDTH-1:0] rate_q;
  logic                 div_clear;
  logic                 div_enable;
  logic                 tick;

  rate_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_divider (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .clear   (div_clear),
    .enable  (div_enable),
    .period  (rate_q),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    div_clear  = 1'b0;
    div_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        div_clear = 1'b1;
        if (START) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        div_enable = !HOLD;
        if (tick && (SELECT == LAST)) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        div_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        div_clear = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Rate is captured only on the START that launches a sweep.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rate_q <= '0;
    end else if ((state == ST_IDLE) && START) begin
      rate_q <= RATE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      SELECT  <= '0;
      CAPTURE <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          SELECT <= '0;
          if (START) begin
            CAPTURE <= '0;
          end
        end
        ST_SCAN: begin
          if (tick) begin
            CAPTURE[SELECT] <= MUX_OUT;
            if (SELECT != LAST) begin
              SELECT <= SELECT + SEL_WIDTH'(1);
            end
          end
        end
        default: begin
          SELECT <= '0;
        end
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = (state == ST_FINISH);

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Directed bench for mux_sweep_ctrl with a behavioural 6-to-1 mux on SW[5:0].
module tb_mux_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hold;
  logic [25:0] rate;
  logic        mux_out;
  logic [2:0]  select;
  logic [5:0]  capture;
  logic        busy;
  logic        done;
  logic [5:0]  sw;

  int errors;
  int checks;

  mux_sweep_ctrl #(
    .DIV_WIDTH(26),
    .LAST_SEL (5)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .START   (start),
    .HOLD    (hold),
    .RATE    (rate),
    .MUX_OUT (mux_out),
    .SELECT  (select),
    .CAPTURE (capture),
    .BUSY    (busy),
    .DONE    (done)
  );

  assign mux_out = (select < 3'd6) ? sw[select] : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Pulse START for one edge; returns with BUSY expected high.
  task automatic kick(input logic [25:0] r, input logic [5:0] s);
    rate  = r;
    sw    = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts BUSY cycles up to and including DONE; bounded.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!done && cycles < 200) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; hold = 1'b0; rate = '0; sw = '0;
    step();
    step();
    checks++;
    if ({select, capture, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got sel=%0d cap=%b busy=%b done=%b, want all zero",
               select, capture, busy, done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rate0;
    kick(26'd0, 6'b101101);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 6) begin
        checks++;
        if (select !== 3'(c - 1) || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL rate0_step c=%0d: got sel=%0d busy=%b done=%b, want sel=%0d busy=1 done=0",
                   c, select, busy, done, c - 1);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || capture !== 6'b101101) begin
          errors++;
          $display("FAIL rate0_done: got done=%b cap=%b, want done=1 cap=101101", done, capture);
        end
      end
      if (c < 7) step();
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || select !== 3'd0) begin
      errors++;
      $display("FAIL rate0_idle: got busy=%b done=%b sel=%0d, want 0 0 0", busy, done, select);
    end
    step();
    step();
    checks++;
    if (capture !== 6'b101101) begin
      errors++;
      $display("FAIL rate0_hold_capture: got %b want 101101", capture);
    end
  endtask

  task automatic test_rate3;
    int cyc;
    kick(26'd3, 6'b010011);
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc <= 24) begin
        checks++;
        if (select !== 3'((cyc - 1) / 4)) begin
          errors++;
          $display("FAIL rate3_dwell c=%0d: got sel=%0d want %0d", cyc, select, (cyc - 1) / 4);
        end
      end
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 25) begin
      errors++;
      $display("FAIL rate3_latency: got %0d want 25", cyc);
    end
    checks++;
    if (capture !== 6'b010011) begin
      errors++;
      $display("FAIL rate3_capture: got %b want 010011", capture);
    end
    step();
  endtask

  task automatic test_hold;
    int cyc;
    kick(26'd2, 6'b110100);
    cyc = 1;
    while (!done && cyc < 200) begin
      hold = (cyc >= 10 && cyc <= 14);
      if (cyc >= 10 && cyc <= 17) begin
        checks++;
        if (select !== 3'd3) begin
          errors++;
          $display("FAIL hold_select c=%0d: got sel=%0d want 3", cyc, select);
        end
      end
      step();
      cyc++;
    end
    hold = 1'b0;
    checks++;
    if (cyc !== 24) begin
      errors++;
      $display("FAIL hold_latency: got %0d want 24", cyc);
    end
    checks++;
    if (capture !== 6'b110100) begin
      errors++;
      $display("FAIL hold_capture: got %b want 110100", capture);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int cyc;
    kick(26'd2, 6'b011001);
    rate = 26'd0;
    cyc = 1;
    while (!done && cyc < 200) begin
      start = (cyc == 5 || cyc == 11);
      if (cyc <= 18) begin
        checks++;
        if (select !== 3'((cyc - 1) / 3)) begin
          errors++;
          $display("FAIL midsweep_dwell c=%0d: got sel=%0d want %0d", cyc, select, (cyc - 1) / 3);
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 19) begin
      errors++;
      $display("FAIL midsweep_latency: got %0d want 19", cyc);
    end
    checks++;
    if (capture !== 6'b011001) begin
      errors++;
      $display("FAIL midsweep_capture: got %b want 011001", capture);
    end
    step();
  endtask

  task automatic test_reset_mid;
    int cyc;
    int done_seen;
    kick(26'd1, 6'b001111);
    cyc = 1;
    while (select !== 3'd4 && cyc < 200) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL rstmid_reach_sel4: got cycle %0d want 9", cyc);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({select, capture, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid_state: got sel=%0d cap=%b busy=%b done=%b, want all zero",
               select, capture, busy, done);
    end
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done: got %0d active cycles want 0", done_seen);
    end
    kick(26'd0, 6'b011010);
    wait_done(cyc);
    checks++;
    if (cyc !== 7 || capture !== 6'b011010) begin
      errors++;
      $display("FAIL rstmid_resweep: got cycles=%0d cap=%b want 7 011010", cyc, capture);
    end
    step();
  endtask

  task automatic test_sw_change;
    int cyc;
    kick(26'd0, 6'b111111);
    wait_done(cyc);
    checks++;
    if (cyc !== 7 || capture !== 6'b111111) begin
      errors++;
      $display("FAIL swchg_first: got cycles=%0d cap=%b want 7 111111", cyc, capture);
    end
    step();
    kick(26'd0, 6'b000001);
    checks++;
    if (capture !== 6'b000000) begin
      errors++;
      $display("FAIL swchg_clear_on_start: got %b want 000000", capture);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 7 || capture !== 6'b000001) begin
      errors++;
      $display("FAIL swchg_second: got cycles=%0d cap=%b want 7 000001", cyc, capture);
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_rate0();
    test_rate3();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sw_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
